matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter DIM, default 64, is the matrix row and column count; legal range is 2..64, and WORDS = DIM*DIM (at most 4096).
REQ-002 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port RST_L, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: one-cycle load request; sampled only in IDLE.
REQ-005 Port s_data, input, 32 bits: inbound stream word, row-major, matrix A first and then matrix B.
REQ-006 Port s_valid, input, 1 bit: s_data is valid.
REQ-007 Port s_ready, output, 1 bit: loader accepts s_data.
REQ-008 Port s_last, input, 1 bit: marks the final word of each matrix.
REQ-009 Port wen, output, 3 bits: matrix write enables to the accelerator; bit 2 is A, bit 1 is B, bit 0 is C.
REQ-010 Port a_data, output, 32 bits: write data for matrix A.
REQ-011 Port b_data, output, 32 bits: write data for matrix B.
REQ-012 Port busy, output, 1 bit: high in LOAD_A, LOAD_B and DONE.
REQ-013 Port done, output, 1 bit: one-cycle pulse when both matrices are written.
REQ-014 Port err, output, 1 bit: sticky framing error (see Configuration).

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD_A, LOAD_B and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD_A on the next edge and clear the word counter and err.
REQ-017 A start pulse outside IDLE SHALL be ignored.
REQ-018 s_ready SHALL be 1 exactly in LOAD_A and LOAD_B; it is a registered state decode and does not depend combinationally on s_valid.
REQ-019 A transfer SHALL occur on each edge where s_valid and s_ready are both 1.
REQ-020 The word counter SHALL be 12 bits, increment per transfer, and wrap to 0 after word WORDS-1.
REQ-021 On a LOAD_A transfer, the next cycle SHALL show wen=3'b100 and a_data=s_data; this is one-cycle latency with registered outputs.
REQ-022 On a LOAD_B transfer, the next cycle SHALL show wen=3'b010 and b_data=s_data.
REQ-023 Cycles with no transfer SHALL produce wen=3'b000; a_data and b_data hold their last value.
REQ-024 wen[0] SHALL always be 0.
REQ-025 Each wen pulse equals exactly one word; the downstream address generator advances one location per write pulse, so stalls (s_valid=0) need no special handling.
REQ-026 The transfer at counter=WORDS-1 in LOAD_A SHALL move the FSM to LOAD_B with the counter at 0.
REQ-027 The transfer at counter=WORDS-1 in LOAD_B SHALL move the FSM to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, coincident with the final wen[1] pulse, then return to IDLE.
REQ-029 The total write pulses per load SHALL be exactly WORDS on wen[2] followed by exactly WORDS on wen[1].
REQ-030 No wen pulse SHALL be issued in IDLE or DONE, other than the final B write that REQ-028 places in DONE.

Reset
REQ-031 RST_L=0 SHALL asynchronously force IDLE, counter=0, wen=0, a_data=0, b_data=0, s_ready=0, busy=0, done=0 and err=0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no further wen pulses; recovery is a fresh start.
REQ-033 Reset release SHALL be synchronous to CLK; the first start is accepted on the first edge after deassertion.

Configuration
REQ-034 Macro MATRIX_LOADER_LAST_CHECK_EN defined: on each transfer, s_last SHALL equal (counter==WORDS-1). On a mismatch, err is set and held until the next accepted start; data is still written and the FSM flow is unchanged.
REQ-035 Macro MATRIX_LOADER_LAST_CHECK_EN undefined: s_last SHALL be ignored and err tied to 0.

Verification
REQ-036 Scenario (DIM=64): start, then 8192 back-to-back words 0..8191 -> 4096 wen=100 pulses with a_data 0..4095, then 4096 wen=010 pulses with b_data 4096..8191, done pulse on the last, busy low after.
REQ-037 Scenario (DIM=2): random s_valid gaps -> exactly 4 A writes then 4 B writes in order; wen=000 on gap cycles.
REQ-038 Scenario: start asserted during LOAD_B -> ignored; counts and done timing unchanged.
REQ-039 Scenario: RST_L pulsed low after 100 A words -> immediate IDLE, all outputs 0; a new start loads A from word 0.
REQ-040 Scenario (macro defined, DIM=2): s_last on word 2 of A -> err=1 and held through DONE; next start clears it; with the macro undefined, err stays 0.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: accepts a row-major stream of matrix A then matrix B and
// turns each accepted word into a one-cycle write pulse towards the
// accelerator's A or B storage.
// Optional feature: define MATRIX_LOADER_LAST_CHECK_EN to check s_last
// framing on every transfer and raise a sticky err on a mismatch.
module matrix_loader #(
    parameter int unsigned DIM = 64
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [2:0]  wen,
    output logic [31:0] a_data,
    output logic [31:0] b_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned WORDS = DIM * DIM;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_LOAD_B = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             xfer;
    logic             last_word;
    logic             start_ok;

    // s_ready is a registered state decode, so the handshake never loops back
    assign xfer      = s_valid & s_ready;
    assign last_word = (cnt == LAST_IDX);
    assign start_ok  = (state == S_IDLE) & start;

    // Next-state and word-counter logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (xfer && last_word) begin
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (xfer && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start_ok) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = last_word ? '0 : cnt + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered write strobes, data and status decoded from the next state
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            wen     <= 3'b000;
            a_data  <= '0;
            b_data  <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wen     <= {xfer && (state == S_LOAD_A), xfer && (state == S_LOAD_B), 1'b0};
            if (xfer && (state == S_LOAD_A)) begin
                a_data <= s_data;
            end
            if (xfer && (state == S_LOAD_B)) begin
                b_data <= s_data;
            end
            s_ready <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
        end
    end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    logic err_d;

    // Sticky framing error: s_last must mark exactly the final word of a matrix
    always_comb begin
        err_d = err;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (xfer && (s_last != last_word)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    logic unused_last;

    // Framing is not checked in this build
    assign unused_last = s_last;
    assign err         = 1'b0;
`endif

endmodule
